// File: rtl/cdseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdseq_pkg
//  Purpose  : Shared types and constants for the countdown sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package cdseq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    REPORT    = 3'd4
  } cdseq_state_e;

  // Length of one countdown in the attached circuit (cycles cd_ready stays low)
  localparam int CD_COUNT_LEN = 8;

  // Default per-wait-state cycle limit before a job is aborted
  localparam int DEFAULT_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/countdown_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_sequencer_if
//  Purpose  : Job request/report port and countdown start/ready link of the
//             countdown sequencer. master = sequencer side, slave = the
//             control logic / countdown circuit side.
//  Revision : 1.0 - initial release
// ============================================================================
interface countdown_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic [CNT_W-1:0] req_runs;
  logic             req_ready;
  logic             cd_start;
  logic             cd_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] done_runs;
  logic             done_err;

  modport master (
    input  req_valid, req_runs, cd_ready,
    output req_ready, cd_start, busy, done, done_runs, done_err
  );

  modport slave (
    output req_valid, req_runs, cd_ready,
    input  req_ready, cd_start, busy, done, done_runs, done_err
  );
endinterface
`default_nettype wire

// File: rtl/cdseq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : cdseq_watchdog
//  Purpose  : Clear/enable up-counter; o_expired flags the TIMEOUT-th
//             consecutive enabled cycle since the last clear.
//  Revision : 1.0 - initial release
// ============================================================================
module cdseq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // Count enabled cycles, saturating at the expiry point; clear has priority
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count starts at 0 on the first cycle, so TIMEOUT-1 marks the last allowed cycle
  assign o_expired = (r_count == W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/countdown_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_sequencer
//  Purpose  : Runs a requested number of countdowns on an attached countdown
//             circuit via start/ready, then reports completion or timeout
//             with a one-cycle done pulse.
//  Options  : CDSEQ_BACK2BACK_EN - restart the countdown directly from
//             WAIT_DONE (start combinational from cd_ready), 9-cycle period.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_sequencer
  import cdseq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  wire logic             clk,
  input  wire logic             rst,
  countdown_sequencer_if.master bus
);

  // A nominal run must fit comfortably inside one watchdog window
  generate
    if (TIMEOUT < CD_COUNT_LEN + 2) begin : g_timeout_chk
      $error("countdown_sequencer: TIMEOUT must be >= 10");
    end
  endgenerate

  cdseq_state_e     r_state;
  cdseq_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_runs;
  logic [CNT_W-1:0] r_completed;
  logic             r_err;

  logic             w_accept;
  logic             w_inc;
  logic             w_timeout;
  logic             w_cd_start;
  logic             w_last;
  logic             w_active;
  logic             w_wd_expired;

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_active = (r_state == LAUNCH) || (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  // Compare one bit wider so the increment can never wrap at runs = 2^CNT_W-1
  assign w_last   = (({1'b0, r_completed} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_runs});

  // Watchdog restarts on every state change; progress wins over expiry
  cdseq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_state_nxt != r_state),
    .i_en      (w_active),
    .o_expired (w_wd_expired)
  );

  // Next-state logic and start request decode
  always_comb begin
    w_state_nxt = r_state;
    w_cd_start  = 1'b0;
    w_inc       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = (bus.req_runs == '0) ? REPORT : LAUNCH;
        end
      end
      LAUNCH: begin
        w_cd_start = 1'b1;
        if (bus.cd_ready) begin
          w_state_nxt = WAIT_BUSY;
        end else if (w_wd_expired) begin
          w_state_nxt = REPORT;
          w_timeout   = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!bus.cd_ready) begin
          w_state_nxt = WAIT_DONE;
        end else if (w_wd_expired) begin
          w_state_nxt = REPORT;
          w_timeout   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.cd_ready) begin
          w_inc = 1'b1;
          if (w_last) begin
            w_state_nxt = REPORT;
          end else begin
`ifdef CDSEQ_BACK2BACK_EN
            w_cd_start  = 1'b1;
            w_state_nxt = WAIT_BUSY;
`else
            w_state_nxt = LAUNCH;
`endif
          end
        end else if (w_wd_expired) begin
          w_state_nxt = REPORT;
          w_timeout   = 1'b1;
        end
      end
      REPORT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, job registers and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_runs      <= '0;
      r_completed <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_runs      <= bus.req_runs;
        r_completed <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_inc) begin
          r_completed <= r_completed + 1'b1;
        end
        if (w_timeout) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = w_active;
  assign bus.done      = (r_state == REPORT);
  assign bus.done_runs = (r_state == REPORT) ? r_completed : '0;
  assign bus.done_err  = (r_state == REPORT) && r_err;
  assign bus.cd_start  = w_cd_start;

endmodule
`default_nettype wire

// File: tb/tb_countdown_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_sequencer
//  Purpose  : Scoreboard bench for countdown_sequencer with a behavioural
//             countdown circuit and fault-injection modes on cd_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 15;
`ifdef CDSEQ_BACK2BACK_EN
  localparam int PERIOD  = 9;
`else
  localparam int PERIOD  = 10;
`endif

  typedef struct {
    int runs;
    int err;
    int cyc;
    int starts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   mode = 0;      // 0 normal circuit, 1 cd_ready stuck 0, 2 cd_ready stuck 1
  int   cd_cnt;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  int   acc_cyc = 0;
  int   nstarts = 0;
  int   last_start = 0;
  bit   chk_rdy = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  countdown_sequencer_if #(.CNT_W(CNT_W)) bus();

  countdown_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 8-count circuit: ready while count is zero
  always @(posedge clk) begin
    if (rst) cd_cnt <= 0;
    else if (bus.cd_start && bus.cd_ready) cd_cnt <= 8;
    else if (cd_cnt > 0) cd_cnt <= cd_cnt - 1;
  end

  assign bus.cd_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (cd_cnt == 0);

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: job outcome from run count, responder mode and accept cycle
  function automatic exp_t model(input int runs, input int md, input int acc);
    exp_t e;
    if (runs == 0)    e = '{0, 0, acc + 1, 0};
    else if (md == 1) e = '{0, 1, acc + 1 + TIMEOUT, 0};
    else if (md == 2) e = '{0, 1, acc + 2 + TIMEOUT, 1};
    else              e = '{runs, 0, acc + 1 + 10 + PERIOD * (runs - 1), runs};
    return e;
  endfunction

  task automatic issue_job(input int runs, output int acc);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_runs  = CNT_W'(runs);
    acc = -1;
    while (acc < 0 && n < 4000) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc;
        sb.push_back(model(runs, mode, acc));
      end
      n++;
    end
    if (acc < 0) check("req_accepted", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_runs  = CNT_W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("job_completes_in_time", sb.size(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  // Monitor: start timing, done reports against scoreboard, req_ready after done
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      nstarts = 0;
      chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        check("req_ready_after_done", bus.req_ready, 1);
        chk_rdy = 1'b0;
      end
      if (bus.cd_start) check("start_while_busy", bus.busy, 1);
      if (bus.cd_start && bus.cd_ready) begin
        if (mode == 0)
          check("start_cycle", cyc, (nstarts == 0) ? acc_cyc + 1 : last_start + PERIOD);
        nstarts++;
        last_start = cyc;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc;
        nstarts = 0;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("done_runs", bus.done_runs, e.runs);
          check("done_err", bus.done_err, e.err);
          check("done_cycle", cyc, e.cyc);
          check("start_count", nstarts, e.starts);
          chk_rdy = 1'b1;
        end
      end
    end
  end

  initial begin
    int acc;
    int runs;
    bus.req_valid = 1'b0;
    bus.req_runs  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_cd_start", bus.cd_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_done_err", bus.done_err, 0);
    check("rst_done_runs", bus.done_runs, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_no_start", bus.cd_start, 0);
    end

    issue_job(1, acc); wait_idle();
    issue_job(3, acc); wait_idle();
    issue_job(0, acc); wait_idle();

    mode = 1;
    issue_job(4, acc); wait_idle();
    mode = 2;
    issue_job(4, acc); wait_idle();
    mode = 0;
    repeat (12) @(posedge clk);

    // Reset on the 5th cycle of the second run of a 3-run job
    issue_job(3, acc);
    do begin
      @(posedge clk); #1;
    end while (cyc < acc + 1 + PERIOD + 4);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_cd_start", bus.cd_start, 0);
    check("midrst_busy", bus.busy, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", bus.done, 0);
    end
    issue_job(1, acc); wait_idle();

    issue_job(255, acc); wait_idle();

    // Random jobs; a short gap keeps the next request held while busy
    for (int j = 0; j < 10; j++) begin
      runs = int'($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue_job(runs, acc);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
